flash_rom_loader: RTL and testbench
===================================

Name: flash_rom_loader

Overview:
- Boot-time loader sitting directly downstream of spi_block: requests a contiguous read from the S25FL032P serial flash, consumes the returned byte stream and writes it into C64 system RAM/ROM shadow.
- Holds the 6510 in reset until the image is loaded, then releases it. One instance per image (BASIC, KERNAL, CHAR).

Parameters:
- FLASH_ADDR, 24'h000000, flash byte address of first image byte
- LOAD_BASE, 16'hA000, first RAM address written
- LOAD_LEN, 16'h2000, bytes to copy (1..65535; 0 is illegal)
- TIMEOUT, 16'hFFFF, clk cycles allowed between consecutive bytes before error

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse, begins a load
- spi_start  out  1  one-cycle pulse to spi_block: open transaction, READ (0x03) at spi_addr
- spi_addr  out  24  flash start address, equals FLASH_ADDR
- spi_byte  in  8  received byte from spi_block
- spi_byte_valid  in  1  spi_byte valid this cycle
- spi_byte_ready  out  1  loader can accept a byte this cycle
- spi_end  out  1  one-cycle pulse: release chip_select, end transaction
- ram_addr  out  16  RAM write address
- ram_data  out  8  RAM write data
- ram_we  out  1  one-cycle write strobe; RAM accepts every strobe
- busy  out  1  load in progress
- done  out  1  load complete, sticky until next start
- error  out  1  byte timeout, sticky until next start
- cpu_hold  out  1  keep CPU in reset

Behaviour:
- Reset (async, reset=0): state IDLE; spi_start=0, spi_end=0, spi_byte_ready=0, ram_we=0, ram_addr=LOAD_BASE, ram_data=0, busy=0, done=0, error=0, cpu_hold=1, counters cleared.
- States: IDLE, CMD, WAIT, WRITE, FINISH, DONE, FAIL.
- IDLE: start=1 -> CMD; busy=1 from next cycle.
- CMD: spi_start=1 for exactly one cycle; byte counter=0, ram_addr=LOAD_BASE, timeout counter=0; -> WAIT.
- WAIT: spi_byte_ready=1. Handshake completes when spi_byte_valid & spi_byte_ready in the same cycle; capture spi_byte into ram_data -> WRITE. Timeout counter increments each WAIT cycle without a handshake; reaching TIMEOUT -> FAIL.
- WRITE: ram_we=1 one cycle, spi_byte_ready=0 (a valid byte here is not accepted; upstream holds it). Byte counter +1; if new count == LOAD_LEN -> FINISH, else ram_addr+1, timeout counter=0 -> WAIT.
- ram_addr arithmetic is 16-bit modulo: FFFF+1 -> 0000 (wrap, no error).
- Throughput: at most one byte per 2 clk; latency handshake -> ram_we = 1 cycle.
- FINISH: spi_end=1 one cycle -> DONE.
- DONE: busy=0, done=1, cpu_hold=0. start=1 -> CMD, done clears, cpu_hold=1 same cycle.
- FAIL: spi_end=1 on entry cycle only; busy=0, error=1, cpu_hold stays 1. start=1 -> CMD, error clears.
- start while busy (CMD/WAIT/WRITE/FINISH): ignored.
- Reset mid-load: immediate return to reset values; no spi_end pulse (spi_block shares reset).

Optional Feature:
- Macro FLASH_ROM_LOADER_CHECKSUM_EN.
- Defined: adds parameter EXP_SUM (8-bit, default 8'h00) and output sum_out[7:0]; 8-bit modulo sum of all written bytes, cleared in CMD. In FINISH, if sum != EXP_SUM, go to FAIL instead of DONE (spi_end still pulses once).
- Not defined: no sum logic or port; FINISH always -> DONE.

Test Plan:
- Reset asserted mid-WAIT after 3 bytes -> all outputs at reset values same cycle, cpu_hold=1, ram_addr=A000.
- LOAD_LEN=4, bytes 11,22,33,44 each valid 1 cycle -> one spi_start, ram_we at A000..A003 with 11..44, one spi_end, done=1, cpu_hold=0.
- spi_byte_valid held high continuously, LOAD_LEN=3 -> exactly 3 writes, one byte per 2 clk, byte during WRITE not consumed.
- LOAD_BASE=FFFE, LOAD_LEN=4 -> writes at FFFE, FFFF, 0000, 0001.
- TIMEOUT=16, no byte after first -> error=1 after 16 WAIT cycles, one spi_end, cpu_hold=1; start -> error clears, reload succeeds.
- CHECKSUM_EN, EXP_SUM=AA, bytes 50,5A -> done=1; bytes 50,5B -> error=1, sum_out=AB.

Source files
------------

// File: rtl/flash_rom_loader.sv
// flash_rom_loader: boot loader copying a flash image from spi_block into RAM, holding the CPU in reset until done.
// Optional checksum verification enabled by defining FLASH_ROM_LOADER_CHECKSUM_EN.
module flash_rom_loader #(
  parameter logic [23:0] FLASH_ADDR = 24'h000000,
  parameter logic [15:0] LOAD_BASE  = 16'hA000,
  parameter logic [15:0] LOAD_LEN   = 16'h2000,
  parameter logic [15:0] TIMEOUT    = 16'hFFFF
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
  , parameter logic [7:0] EXP_SUM   = 8'h00
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        spi_start,
  output logic [23:0] spi_addr,
  input  logic [7:0]  spi_byte,
  input  logic        spi_byte_valid,
  output logic        spi_byte_ready,
  output logic        spi_end,
  output logic [15:0] ram_addr,
  output logic [7:0]  ram_data,
  output logic        ram_we,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
  , output logic [7:0] sum_out
`endif
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d, tmo_q, tmo_d, addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        fent_q, fent_d;
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
  logic [7:0]  sum_q, sum_d;
  assign sum_out = sum_q;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    addr_d  = addr_q;
    data_d  = data_q;
    fent_d  = 1'b0;
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_FAIL: state_d = start ? S_CMD : state_q;
      S_CMD: begin
        cnt_d   = '0;
        tmo_d   = '0;
        addr_d  = LOAD_BASE;
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
        sum_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (spi_byte_valid) begin
          data_d  = spi_byte;
          state_d = S_WRITE;
        end else begin
          tmo_d   = tmo_q + 16'd1;
          fent_d  = (tmo_d == TIMEOUT);
          state_d = fent_d ? S_FAIL : S_WAIT;
        end
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 16'd1;
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
        sum_d   = sum_q + data_q;
`endif
        if (cnt_d == LOAD_LEN) begin
          state_d = S_FINISH;
        end else begin
          addr_d  = addr_q + 16'd1;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
      S_FINISH: state_d = (sum_q == EXP_SUM) ? S_DONE : S_FAIL;
`else
      S_FINISH: state_d = S_DONE;
`endif
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tmo_q   <= '0;
      addr_q  <= LOAD_BASE;
      data_q  <= '0;
      fent_q  <= 1'b0;
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      fent_q  <= fent_d;
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end
  // spi_end in FAIL only on a timeout entry; a checksum failure already pulsed it in FINISH
  assign spi_start      = (state_q == S_CMD);
  assign spi_addr       = FLASH_ADDR;
  assign spi_byte_ready = (state_q == S_WAIT);
  assign spi_end        = (state_q == S_FINISH) || (state_q == S_FAIL && fent_q);
  assign ram_addr       = addr_q;
  assign ram_data       = data_q;
  assign ram_we         = (state_q == S_WRITE);
  assign busy           = (state_q == S_CMD) || (state_q == S_WAIT) || (state_q == S_WRITE) || (state_q == S_FINISH);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_FAIL);
  assign cpu_hold       = (state_q != S_DONE);
endmodule

// File: tb/tb_flash_rom_loader.sv
// tb_flash_rom_loader: directed scoreboard bench for flash_rom_loader (wrapping base, timeout, reset mid-load).
module tb_flash_rom_loader;
  localparam logic [23:0] FA = 24'h123456;
  localparam logic [15:0] LB = 16'hFFFE;
  typedef struct packed { logic [15:0] a; logic [7:0] d; int c; } wr_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, spi_byte_valid = 1'b0;
  logic [7:0] spi_byte = 8'h00;
  logic spi_start, spi_byte_ready, spi_end, ram_we, busy, done, error, cpu_hold;
  logic [23:0] spi_addr;
  logic [15:0] ram_addr;
  logic [7:0] ram_data;
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
  logic [7:0] sum_out;
`endif
  int total = 0, bad = 0, cyc = 0, n_start = 0, n_end = 0;
  logic [15:0] ea;
  logic [23:0] exp_q[$];
  wr_t obs_q[$];
  logic [7:0] bv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  flash_rom_loader #(.FLASH_ADDR(FA), .LOAD_BASE(LB), .LOAD_LEN(16'd4), .TIMEOUT(16'd16)
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
    , .EXP_SUM(8'hAA)
`endif
  ) dut (
    .clk(clk), .reset(reset), .start(start), .spi_start(spi_start), .spi_addr(spi_addr),
    .spi_byte(spi_byte), .spi_byte_valid(spi_byte_valid), .spi_byte_ready(spi_byte_ready),
    .spi_end(spi_end), .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
    , .sum_out(sum_out)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (spi_start) n_start <= n_start + 1;
    if (spi_end) n_end <= n_end + 1;
    if (ram_we) obs_q.push_back('{a: ram_addr, d: ram_data, c: cyc});
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ea = LB;
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    spi_byte = b;
    spi_byte_valid = 1'b1;
    while (!spi_byte_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 32'(spi_byte_ready), 32'd1);
    exp_q.push_back({ea, b});
    ea = ea + 16'd1;
    @(negedge clk);
    spi_byte_valid = 1'b0;
  endtask
  task automatic finish_chk(input string tag);
    @(negedge clk);
    chk({tag, "_end"}, 32'(spi_end), 32'd1);
    @(negedge clk);
    chk({tag, "_status"}, 32'({busy, done, error, cpu_hold}), 32'b0100);
  endtask
  task automatic drain(input string tag, input bit gap);
    wr_t o;
    logic [23:0] e;
    int prev = -1;
    chk({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk({tag, "_wr"}, 32'({o.a, o.d}), 32'(e));
      if (gap && prev >= 0) chk({tag, "_gap"}, 32'(o.c - prev), 32'd2);
      prev = o.c;
    end
    exp_q.delete();
    obs_q.delete();
  endtask
  initial begin
    int n, s0, e0;
    repeat (2) @(negedge clk);
    chk("rst_flags", 32'({spi_start, spi_end, spi_byte_ready, ram_we, busy, done, error, cpu_hold}), 32'b00000001);
    chk("rst_addr", 32'(ram_addr), 32'(LB));
    chk("rst_data", 32'(ram_data), 32'd0);
    chk("spi_addr", 32'(spi_addr), 32'(FA));
    reset = 1'b1;
    @(negedge clk);
    // load 1: single-cycle valid bytes, wrapping addresses
    pulse_start();
    chk("l1_cmd", 32'({spi_start, busy}), 32'b11);
    for (int i = 0; i < 4; i++) send(bv[i]);
    finish_chk("l1");
`ifdef FLASH_ROM_LOADER_CHECKSUM_EN
    chk("l1_sum", 32'(sum_out), 32'hAA);
`endif
    drain("l1", 1'b0);
    chk("l1_starts", 32'(n_start), 32'd1);
    chk("l1_ends", 32'(n_end), 32'd1);
    // load 2: valid held high, upstream advances only after acceptance
    pulse_start();
    chk("l2_cmd", 32'({done, cpu_hold, busy}), 32'b011);
    spi_byte = bv[0];
    spi_byte_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({ea, bv[i]});
      ea = ea + 16'd1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!ram_we && n < 20);
      chk("l2_we", 32'(ram_we), 32'd1);
      spi_byte = (i < 3) ? bv[(i + 1) % 4] : 8'h00;
    end
    spi_byte_valid = 1'b0;
    finish_chk("l2");
    drain("l2", 1'b1);
    chk("l2_ends", 32'(n_end), 32'd2);
    // load 3: one byte then silence -> timeout; start while busy ignored
    s0 = n_start;
    pulse_start();
    send(bv[0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (spi_byte_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("l3_wait_cycles", 32'(n), 32'd16);
    chk("l3_fail_end", 32'(spi_end), 32'd1);
    chk("l3_status", 32'({busy, done, error, cpu_hold}), 32'b0011);
    @(negedge clk);
    chk("l3_end_once", 32'(spi_end), 32'd0);
    chk("l3_starts", 32'(n_start - s0), 32'd1);
    chk("l3_ends", 32'(n_end), 32'd3);
    drain("l3", 1'b0);
    // load 4: recovery from FAIL
    pulse_start();
    chk("l4_cmd", 32'({error, busy, spi_start}), 32'b011);
    for (int i = 0; i < 4; i++) send(bv[i]);
    finish_chk("l4");
    drain("l4", 1'b0);
    // load 5: reset during WAIT after three bytes
    pulse_start();
    for (int i = 0; i < 3; i++) send(bv[i]);
    @(negedge clk);
    chk("l5_in_wait", 32'(spi_byte_ready), 32'd1);
    e0 = n_end;
    reset = 1'b0;
    #1;
    chk("l5_rst_flags", 32'({spi_start, spi_end, spi_byte_ready, ram_we, busy, done, error, cpu_hold}), 32'b00000001);
    chk("l5_rst_addr", 32'(ram_addr), 32'(LB));
    chk("l5_rst_data", 32'(ram_data), 32'd0);
    drain("l5", 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("l5_no_end", 32'(n_end - e0), 32'd0);
    chk("l5_idle", 32'({busy, done, error, cpu_hold}), 32'b0001);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
